// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_BLANK_EN to blank leading zero digits (written as 4'hF) in the registered result.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [BIN_W-1:0] shift_reg;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] adjusted;
  logic [BCD_W-1:0] scratch_next;
  logic [BCD_W-1:0] result;
  logic [CNT_W-1:0] count;
  logic             ovf_trk;
  logic             carry_out;

  // Add-3 correction per digit, then the single-bit shift of {scratch, shift_reg}.
  always_comb begin
    adjusted = scratch;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5)
        adjusted[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
    carry_out    = adjusted[BCD_W-1];
    scratch_next = {adjusted[BCD_W-2:0], shift_reg[BIN_W-1]};
  end

`ifdef BIN2BCD_BLANK_EN
  logic leading;

  // Scan from the top digit down; digit 0 is excluded so a zero result still shows "0".
  always_comb begin
    result  = scratch_next;
    leading = 1'b1;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      if (leading && (scratch_next[4*k +: 4] == 4'd0))
        result[4*k +: 4] = 4'hF;
      else
        leading = 1'b0;
    end
  end
`else
  always_comb begin
    result = scratch_next;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
      shift_reg <= '0;
      scratch   <= '0;
      count     <= '0;
      ovf_trk   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            scratch   <= '0;
            ovf_trk   <= 1'b0;
            count     <= CNT_W'(BIN_W);
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= scratch_next;
          shift_reg <= shift_reg << 1;
          count     <= count - CNT_W'(1);
          ovf_trk   <= ovf_trk | carry_out;
          if (count == CNT_W'(1)) begin
            bcd      <= result;
            overflow <= ovf_trk | carry_out;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 3-digit and a 2-digit instance share stimulus,
// expectations come from a decimal-arithmetic model, a negedge monitor checks each done.
module tb_bin2bcd_seq;

  localparam int BIN_W = 8;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin   = '0;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t q3[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
  );

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
  );

  function automatic exp_t model(input int unsigned v, input int unsigned nd);
    int unsigned lim;
    int unsigned m;
    int unsigned msd;
    logic [3:0]  dg;
    exp_t        e;
    lim = 1;
    for (int i = 0; i < int'(nd); i++) lim = lim * 10;
    e.ovf = (v >= lim);
    e.bcd = '0;
    m     = v % lim;
    msd   = 0;
    for (int i = 0; i < int'(nd); i++) begin
      if (((m / (10 ** i)) % 10) != 0) msd = i;
    end
    for (int i = 0; i < int'(nd); i++) begin
      dg = 4'((m / (10 ** i)) % 10);
`ifdef BIN2BCD_BLANK_EN
      if (i > int'(msd)) dg = 4'hF;
`endif
      e.bcd[4*i +: 4] = dg;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int unsigned v);
    q3.push_back(model(v, 3));
    q2.push_back(model(v, 2));
  endtask

  task automatic start_conv(input int unsigned v);
    start = 1'b1;
    bin   = 8'(v);
    push(v);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done3 && n < 40);
    check("done_seen", 32'(done3), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every done and measures latency/busy width.
  initial begin
    int   lat;
    int   bcnt;
    bit   waiting;
    exp_t e;
    lat = 0; bcnt = 0; waiting = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        waiting = 0;
      end else begin
        if (waiting) begin
          lat++;
          if (busy3) bcnt++;
        end
        if (done3 || done2) begin
          check("done_align", 32'(done2), 32'(done3));
          if (q3.size() == 0 || q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with bcd3=%0h, required no done", bcd3);
          end else begin
            e = q3.pop_front();
            check("bcd3", 32'(bcd3), 32'(e.bcd));
            check("ovf3", 32'(ovf3), 32'(e.ovf));
            e = q2.pop_front();
            check("bcd2", 32'(bcd2), 32'(e.bcd[7:0]));
            check("ovf2", 32'(ovf2), 32'(e.ovf));
          end
          if (waiting) begin
            check("latency", lat, BIN_W);
            check("busy_cycles", bcnt, BIN_W);
          end
          waiting = 0;
        end
        if (start && !busy3) begin
          waiting = 1;
          lat     = -1;
          bcnt    = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned v;
    int unsigned gap;
    int unsigned fixed_v[6] = '{99, 100, 9, 10, 254, 1};

    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_done", 32'(done3), 32'd0);
    check("rst_bcd", 32'(bcd3), 32'd0);
    check("rst_ovf", 32'(ovf3), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    start_conv(0);
    wait_done();

    start_conv(255);
    wait_done();
    start_conv(42);   // issued in the done cycle: back-to-back
    wait_done();

    start_conv(150);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    bin   = 8'd99;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    start_conv(200);
    wait_done();
    start_conv(99);
    wait_done();

    start_conv(200);
    wait_done();
    start_conv(123);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy3", 32'(busy3), 32'd0);
    check("midrst_done3", 32'(done3), 32'd0);
    check("midrst_bcd3", 32'(bcd3), 32'd0);
    check("midrst_ovf3", 32'(ovf3), 32'd0);
    check("midrst_bcd2", 32'(bcd2), 32'd0);
    check("midrst_ovf2", 32'(ovf2), 32'd0);
    void'(q3.pop_back());
    void'(q2.pop_back());
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    start_conv(10);
    wait_done();

    // Held start: re-triggers on reaching IDLE.
    start = 1'b1;
    bin   = 8'd33;
    push(33);
    wait_done();
    push(33);
    wait_done();
    start = 1'b0;

    foreach (fixed_v[i]) begin
      @(posedge clk); #1;
      start_conv(fixed_v[i]);
      wait_done();
    end

    repeat (25) begin
      v   = $urandom_range(0, 255);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      start_conv(v);
      wait_done();
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(q3.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
